pipe_skid_reg: RTL and testbench

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg_if.sv | 27 ++
 rtl/pipe_skid_reg.sv | 165 ++++++++++++++++
 tb/tb_pipe_skid_reg.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_skid_reg_if.sv
// Handshake bundle for pipe_skid_reg: upstream (in_*) and downstream (out_*)
// valid/ready channels carrying a payload word and a control-field vector.
// master: the surrounding pipeline (drives in_* and out_ready).
// slave : the skid register itself.
interface pipe_skid_reg_if #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;

    modport master (
        output in_valid, in_data, in_ctrl, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl
    );

    modport slave (
        input  in_valid, in_data, in_ctrl, out_ready,
        output in_ready, out_valid, out_data, out_ctrl
    );
endinterface

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry pipeline skid register (main + skid).
// The main register drives the out_* ports; the skid register catches the
// one entry that arrives while the downstream stage is stalling. in_ready
// is a registered decode of the state, so out_ready never reaches it
// combinationally. Empty main slots are held at zero so a bubble never
// asserts a control field.
// Optional feature: define PIPE_SKID_STATS_EN to add saturating
// back-pressure (stall_cnt) and flush (flush_cnt) counters.
module pipe_skid_reg #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             flush,
    pipe_skid_reg_if.slave   bus
`ifdef PIPE_SKID_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            state_r;
    logic [DATA_W-1:0] main_data_r;
    logic [CTRL_W-1:0] main_ctrl_r;
    logic [DATA_W-1:0] skid_data_r;
    logic [CTRL_W-1:0] skid_ctrl_r;
    logic              out_valid_r;
    logic              in_ready_r;

    logic              in_xfer_s;
    logic              out_xfer_s;

    assign in_xfer_s  = bus.in_valid & in_ready_r;
    assign out_xfer_s = out_valid_r & bus.out_ready;

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = main_data_r;
    assign bus.out_ctrl  = main_ctrl_r;

    // State machine and entry storage; flush overrides every transfer.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r     <= ST_EMPTY;
            main_data_r <= {DATA_W{1'b0}};
            main_ctrl_r <= {CTRL_W{1'b0}};
            skid_data_r <= {DATA_W{1'b0}};
            skid_ctrl_r <= {CTRL_W{1'b0}};
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else if (flush) begin
            state_r     <= ST_EMPTY;
            main_data_r <= {DATA_W{1'b0}};
            main_ctrl_r <= {CTRL_W{1'b0}};
            skid_data_r <= {DATA_W{1'b0}};
            skid_ctrl_r <= {CTRL_W{1'b0}};
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_xfer_s) begin
                        main_data_r <= bus.in_data;
                        main_ctrl_r <= bus.in_ctrl;
                        out_valid_r <= 1'b1;
                        state_r     <= ST_ONE;
                    end else begin
                        state_r     <= ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (in_xfer_s && out_xfer_s) begin
                        // Streaming: head leaves, new entry replaces it.
                        main_data_r <= bus.in_data;
                        main_ctrl_r <= bus.in_ctrl;
                        state_r     <= ST_ONE;
                    end else if (in_xfer_s) begin
                        // Head stalled: park the newcomer in skid.
                        skid_data_r <= bus.in_data;
                        skid_ctrl_r <= bus.in_ctrl;
                        in_ready_r  <= 1'b0;
                        state_r     <= ST_FULL;
                    end else if (out_xfer_s) begin
                        main_data_r <= {DATA_W{1'b0}};
                        main_ctrl_r <= {CTRL_W{1'b0}};
                        out_valid_r <= 1'b0;
                        state_r     <= ST_EMPTY;
                    end else begin
                        state_r     <= ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (out_xfer_s) begin
                        main_data_r <= skid_data_r;
                        main_ctrl_r <= skid_ctrl_r;
                        skid_data_r <= {DATA_W{1'b0}};
                        skid_ctrl_r <= {CTRL_W{1'b0}};
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_ONE;
                    end else begin
                        state_r     <= ST_FULL;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a clean empty state.
                    state_r     <= ST_EMPTY;
                    main_data_r <= {DATA_W{1'b0}};
                    main_ctrl_r <= {CTRL_W{1'b0}};
                    skid_data_r <= {DATA_W{1'b0}};
                    skid_ctrl_r <= {CTRL_W{1'b0}};
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

`ifdef PIPE_SKID_STATS_EN
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;

    // Statistics counters; deliberately untouched by flush.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (out_valid_r && !bus.out_ready) begin
                stall_cnt_r <= sat_inc(stall_cnt_r);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (flush) begin
                flush_cnt_r <= sat_inc(flush_cnt_r);
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end
`else
    // Statistics disabled: no counter ports or counter state.
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg. A queue-based model (at most two
// entries, pop head on output transfer, push on input transfer, flush
// empties it) is compared with the DUT on every falling clock edge, and
// directed scenarios pin the model with literal expectations.
module tb_pipe_skid_reg;
    localparam int DATA_W  = 64;
    localparam int CTRL_W  = 8;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic [CTRL_W-1:0] c;
    } ent_t;

    logic CLK  = 1'b0;
    logic nRST;
    logic flush;

    pipe_skid_reg_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus();

`ifdef PIPE_SKID_STATS_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
`endif

    pipe_skid_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .flush     (flush),
        .bus       (bus)
`ifdef PIPE_SKID_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    int pops   = 0;
    logic [DATA_W-1:0] last_pop = '0;

    ent_t q[$];
    ent_t e;
    int   m_stall = 0;
    int   m_flush = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on each rising edge, from the pre-edge occupancy.
    always @(posedge CLK) begin
        if (nRST === 1'b1) begin
            int n;
            n = q.size();
            if (flush) begin
                q.delete();
            end else begin
                if (n > 0 && bus.out_ready) void'(q.pop_front());
                if (bus.in_valid && n < 2) begin
                    e.d = bus.in_data;
                    e.c = bus.in_ctrl;
                    q.push_back(e);
                end
            end
            if (n > 0 && !bus.out_ready && m_stall < CNT_MAX) m_stall++;
            if (flush && m_flush < CNT_MAX) m_flush++;
        end
    end

    // Reset empties the model at once.
    always @(negedge nRST) begin
        q.delete();
        m_stall = 0;
        m_flush = 0;
    end

    // Compare process: DUT outputs against the model every falling edge.
    always @(negedge CLK) begin
        check("in_ready", 64'(bus.in_ready), 64'(q.size() < 2));
        check("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
        if (q.size() > 0) begin
            check("out_data", 64'(bus.out_data), 64'(q[0].d));
            check("out_ctrl", 64'(bus.out_ctrl), 64'(q[0].c));
        end else begin
            check("bubble_ctrl", 64'(bus.out_ctrl), 64'd0);
        end
`ifdef PIPE_SKID_STATS_EN
        check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
        check("flush_cnt", 64'(flush_cnt), 64'(m_flush));
`endif
    end

    // Record the output transfer that the next rising edge will perform,
    // then advance to just after the following falling edge.
    task automatic step();
        if (bus.out_valid && bus.out_ready) begin
            pops++;
            last_pop = bus.out_data;
        end
        @(negedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_ctrl  = c;
    endtask

    initial begin
        int p0;
        int rdy_low;
        nRST = 1'b0;
        flush = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, '0, '0);
        repeat (3) @(negedge CLK);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_out_ctrl", 64'(bus.out_ctrl), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        nRST = 1'b1;

        // Latency-one load.
        bus.out_ready = 1'b1;
        drive(1'b1, 64'h1234, 8'h05);
        step();
        check("lat1_valid", 64'(bus.out_valid), 64'd1);
        check("lat1_data", 64'(bus.out_data), 64'h1234);
        check("lat1_ctrl", 64'(bus.out_ctrl), 64'h05);
        drive(1'b0, '0, '0);
        step();
        check("lat1_drained", 64'(bus.out_valid), 64'd0);

        // Skid fill then in-order drain.
        bus.out_ready = 1'b0;
        drive(1'b1, 64'hA, 8'h01);
        step();
        drive(1'b1, 64'hB, 8'h02);
        step();
        check("full_in_ready", 64'(bus.in_ready), 64'd0);
        check("full_head_a", 64'(bus.out_data), 64'hA);
        drive(1'b0, '0, '0);
        bus.out_ready = 1'b1;
        step();
        check("drain_head_b", 64'(bus.out_data), 64'hB);
        check("drain_valid_b", 64'(bus.out_valid), 64'd1);
        check("drain_in_ready", 64'(bus.in_ready), 64'd1);
        step();
        check("drain_empty", 64'(bus.out_valid), 64'd0);

        // Flush in FULL drops the offered entry.
        bus.out_ready = 1'b0;
        drive(1'b1, 64'h21, 8'h11);
        step();
        drive(1'b1, 64'h22, 8'h12);
        step();
        flush = 1'b1;
        drive(1'b1, 64'hC, 8'h33);
        step();
        check("flush_valid", 64'(bus.out_valid), 64'd0);
        check("flush_ctrl", 64'(bus.out_ctrl), 64'd0);
        check("flush_in_ready", 64'(bus.in_ready), 64'd1);
        flush = 1'b0;
        drive(1'b0, '0, '0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("flush_no_c", 64'(bus.out_valid), 64'd0);
        end

        // Asynchronous reset while FULL.
        bus.out_ready = 1'b0;
        drive(1'b1, 64'h31, 8'h01);
        step();
        drive(1'b1, 64'h32, 8'h02);
        step();
        drive(1'b0, '0, '0);
        #2 nRST = 1'b0;
        #1;
        check("arst_out_valid", 64'(bus.out_valid), 64'd0);
        check("arst_in_ready", 64'(bus.in_ready), 64'd1);
        check("arst_out_ctrl", 64'(bus.out_ctrl), 64'd0);
        step();
        nRST = 1'b1;

        // Stall saturation and flush counting (counters fresh from reset).
        drive(1'b1, 64'h77, 8'h07);
        step();
        drive(1'b0, '0, '0);
        repeat (20) step();
        check("stall_head_held", 64'(bus.out_data), 64'h77);
`ifdef PIPE_SKID_STATS_EN
        check("stall_sat", 64'(stall_cnt), 64'(CNT_MAX));
`endif
        for (int i = 0; i < 3; i++) begin
            flush = 1'b1;
            step();
            flush = 1'b0;
            step();
        end
`ifdef PIPE_SKID_STATS_EN
        check("flush_cnt3", 64'(flush_cnt), 64'd3);
        check("stall_kept", 64'(stall_cnt), 64'(CNT_MAX));
`endif

        // Full-rate streaming of 100 incrementing entries.
        bus.out_ready = 1'b1;
        p0 = pops;
        rdy_low = 0;
        for (int i = 0; i < 100; i++) begin
            if (!bus.in_ready) rdy_low++;
            drive(1'b1, 64'(i + 1), 8'(i));
            step();
        end
        check("stream_rate", 64'(pops - p0), 64'd99);
        drive(1'b0, '0, '0);
        step();
        check("stream_count", 64'(pops - p0), 64'd100);
        check("stream_last", 64'(last_pop), 64'd100);
        check("stream_ready", 64'(rdy_low), 64'd0);

        // Randomized traffic with occasional flush.
        for (int i = 0; i < 1500; i++) begin
            bus.out_ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 39) == 0);
            drive($urandom_range(0, 3) != 0, {$urandom, $urandom}, 8'($urandom));
            step();
        end
        flush = 1'b0;
        drive(1'b0, '0, '0);
        bus.out_ready = 1'b1;
        repeat (3) step();
        check("final_empty", 64'(bus.out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
